// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-class character LCD controller:
// command bytes, the init command list and the controller/bus state types.
package lcd_pkg;

  // HD44780 command bytes used by the controller
  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] LCD_CLEAR     = 8'h01;  // clear display, home cursor (slow)
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;  // increment address, no shift
  localparam logic [7:0] LCD_DDRAM_L1  = 8'h80;  // set DDRAM address 0 (line 1, col 0)

  // Index of the last entry in the init command list
  localparam logic [1:0] INIT_LAST = 2'd3;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_CHAR  = 3'd4
  } lcd_state_e;

  // Phases of a single bus transfer
  typedef enum logic [1:0] {
    XF_IDLE  = 2'd0,
    XF_SETUP = 2'd1,
    XF_EN    = 2'd2,
    XF_WAIT  = 2'd3
  } xfer_phase_e;

  // Init command list, issued in index order after power-up
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0: init_cmd = LCD_FUNC_8B2L;
      2'd1: init_cmd = LCD_DISP_ON;
      2'd2: init_cmd = LCD_CLEAR;
      2'd3: init_cmd = LCD_ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus transfer: a setup cycle with rs/data driven and E low, EN_CYC
// cycles of E high, then a post-transfer wait with E low (CLR_CYC when the
// caller flags a slow command, CMD_CYC otherwise). rs/data are held from setup
// until the next transfer's setup. done is high in the last wait cycle.
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int EN_CYC  = 24,
  parameter int CMD_CYC = 2000,
  parameter int CLR_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  // Counter covers the longest of the three phase lengths
  localparam int MAX_AB = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAXW   = (CLR_CYC > MAX_AB) ? CLR_CYC : MAX_AB;
  localparam int CW     = $clog2(MAXW + 1);

  localparam logic [CW-1:0] EN_LOAD  = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYC - 1);

  xfer_phase_e   phase_reg;
  logic [CW-1:0] cnt_reg;
  logic          long_reg;

  // The controller never reads the LCD
  assign lcd_rw = 1'b0;

  // Last wait cycle: the caller may queue the next transfer now
  assign done = (phase_reg == XF_WAIT) && (cnt_reg == '0);

  // Transfer phase sequencer; counter reloads on every phase entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= XF_IDLE;
      cnt_reg   <= '0;
      long_reg  <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      case (phase_reg)
        XF_IDLE: begin
          if (start) begin
            lcd_rs    <= rs;
            lcd_data  <= data;
            long_reg  <= long_wait;
            phase_reg <= XF_SETUP;
          end
        end
        XF_SETUP: begin
          lcd_e     <= 1'b1;
          cnt_reg   <= EN_LOAD;
          phase_reg <= XF_EN;
        end
        XF_EN: begin
          if (cnt_reg == '0) begin
            lcd_e     <= 1'b0;
            cnt_reg   <= long_reg ? CLR_LOAD : CMD_LOAD;
            phase_reg <= XF_WAIT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        XF_WAIT: begin
          if (cnt_reg == '0) begin
            phase_reg <= XF_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          phase_reg <= XF_IDLE;
          lcd_e     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_hex_display_ctrl.sv
// HD44780-class 8-bit LCD controller: power-up delay, init command list, then
// on request writes a NDIGITS-wide hex value as ASCII to line 1. Requests that
// arrive while busy are remembered (latest value wins) and served from IDLE.
module lcd_hex_display_ctrl
  import lcd_pkg::*;
#(
  parameter int NDIGITS   = 8,
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 24,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 82000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic                   busy,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_e,
  output logic [7:0]             lcd_data
);

  localparam int PW = $clog2(PWRUP_CYC + 1);
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [PW-1:0] PWRUP_LOAD = PW'(PWRUP_CYC - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NDIGITS - 1);

  lcd_state_e             state_reg;
  logic [PW-1:0]          pwr_cnt_reg;
  logic [1:0]             init_idx_reg;
  logic [DW-1:0]          digit_idx_reg;
  logic [4*NDIGITS-1:0]   frame_reg;
  logic                   pend_reg;
  logic                   busy_reg;

  // Request registers towards the bus transfer engine
  logic                   start_reg;
  logic                   xfer_rs_reg;
  logic [7:0]             xfer_data_reg;
  logic                   xfer_long_reg;
  logic                   xfer_done;

  logic [1:0]             init_idx_next;
  logic [DW-1:0]          digit_idx_next;
  logic [7:0]             init_next_cmd;
  logic [3:0]             nib [NDIGITS];

  // Nibble -> ASCII hex digit, every code listed explicitly
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    case (n)
      4'h0: nib_to_ascii = 8'h30;
      4'h1: nib_to_ascii = 8'h31;
      4'h2: nib_to_ascii = 8'h32;
      4'h3: nib_to_ascii = 8'h33;
      4'h4: nib_to_ascii = 8'h34;
      4'h5: nib_to_ascii = 8'h35;
      4'h6: nib_to_ascii = 8'h36;
      4'h7: nib_to_ascii = 8'h37;
      4'h8: nib_to_ascii = 8'h38;
      4'h9: nib_to_ascii = 8'h39;
      4'hA: nib_to_ascii = 8'h41;
      4'hB: nib_to_ascii = 8'h42;
      4'hC: nib_to_ascii = 8'h43;
      4'hD: nib_to_ascii = 8'h44;
      4'hE: nib_to_ascii = 8'h45;
      4'hF: nib_to_ascii = 8'h46;
    endcase
  endfunction

  // Digit k is shown at column k; digit 0 is the most significant nibble
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_nib
    assign nib[gi] = frame_reg[4*(NDIGITS-gi)-1 -: 4];
  end

  assign init_idx_next  = init_idx_reg + 2'd1;
  assign digit_idx_next = digit_idx_reg + 1'b1;
  assign init_next_cmd  = init_cmd(init_idx_next);
  assign busy           = busy_reg;

  lcd_bus_xfer #(
    .EN_CYC  (EN_CYC),
    .CMD_CYC (CMD_CYC),
    .CLR_CYC (CLR_CYC)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .start     (start_reg),
    .rs        (xfer_rs_reg),
    .data      (xfer_data_reg),
    .long_wait (xfer_long_reg),
    .done      (xfer_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  // Main sequencer: power-up, init list, then address + digit frames on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_PWRUP;
      pwr_cnt_reg   <= PWRUP_LOAD;
      init_idx_reg  <= 2'd0;
      digit_idx_reg <= '0;
      frame_reg     <= '0;
      pend_reg      <= 1'b0;
      busy_reg      <= 1'b1;
      start_reg     <= 1'b0;
      xfer_rs_reg   <= 1'b0;
      xfer_data_reg <= 8'h00;
      xfer_long_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      // Any request is remembered; IDLE consumes it below
      if (load) begin
        pend_reg <= 1'b1;
      end
      case (state_reg)
        ST_PWRUP: begin
          if (pwr_cnt_reg == '0) begin
            state_reg     <= ST_INIT;
            init_idx_reg  <= 2'd0;
            start_reg     <= 1'b1;
            xfer_rs_reg   <= 1'b0;
            xfer_data_reg <= init_cmd(2'd0);
            xfer_long_reg <= (init_cmd(2'd0) == LCD_CLEAR);
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg - 1'b1;
          end
        end
        ST_INIT: begin
          if (xfer_done) begin
            if (init_idx_reg == INIT_LAST) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              init_idx_reg  <= init_idx_next;
              start_reg     <= 1'b1;
              xfer_rs_reg   <= 1'b0;
              xfer_data_reg <= init_next_cmd;
              xfer_long_reg <= (init_next_cmd == LCD_CLEAR);
            end
          end
        end
        ST_IDLE: begin
          if (load || pend_reg) begin
            frame_reg     <= value;
            pend_reg      <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_ADDR;
            start_reg     <= 1'b1;
            xfer_rs_reg   <= 1'b0;
            xfer_data_reg <= LCD_DDRAM_L1;
            xfer_long_reg <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (xfer_done) begin
            state_reg     <= ST_CHAR;
            digit_idx_reg <= '0;
            start_reg     <= 1'b1;
            xfer_rs_reg   <= 1'b1;
            xfer_data_reg <= nib_to_ascii(nib[0]);
            xfer_long_reg <= 1'b0;
          end
        end
        ST_CHAR: begin
          if (xfer_done) begin
            if (digit_idx_reg == DIGIT_LAST) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              digit_idx_reg <= digit_idx_next;
              start_reg     <= 1'b1;
              xfer_rs_reg   <= 1'b1;
              xfer_data_reg <= nib_to_ascii(nib[digit_idx_next]);
              xfer_long_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_PWRUP;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule
